fetch_unit: RTL and testbench

Parametrised successor to the single-word PC/fetch stage. It keeps a fetch PC and issues word requests to instruction memory over a valid/valid handshake, then selects the 32-bit instruction from a 64-bit memory beat. Fetched instructions go into a small prefetch queue that feeds decode. It also supports branch/jump redirect with flush and discard of an in-flight response. The block sits between instruction memory and decode.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: keeps the fetch PC, requests 64-bit beats from instruction memory,
// picks the addressed 32-bit half into a small prefetch queue and feeds decode.
// Redirects flush the queue and discard a response that is still in flight.
module fetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2,
    parameter logic [31:0]     NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_addr_valid,
    input  logic            inst_mem_valid,
    input  logic [63:0]     inst_mem,
    output logic [31:0]     inst_out,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid
);

    localparam int unsigned     PW    = $clog2(QDEPTH);
    localparam int unsigned     CW    = PW + 1;
    localparam logic [CW-1:0]   QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_after;
    logic [XLEN-1:0] q_pc   [QDEPTH];
    logic [31:0]     q_inst [QDEPTH];
    logic            push, pop;
    logic [XLEN-1:0] req_addr;
    logic [31:0]     sel_inst;

    // Redirect targets are word aligned, so the low two bits are dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Next-state, queue bookkeeping and decode-side outputs.
    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        hold_d    = hold_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        req_addr  = {fpc_q[XLEN-1:3], 3'b000};
        sel_inst  = fpc_q[2] ? inst_mem[63:32] : inst_mem[31:0];

        inst_valid = (cnt_q != '0) && !stall && !redirect_valid;
        pop        = inst_valid;
        cnt_after  = cnt_q + CW'(1) - CW'(pop);

        unique case (state_q)
            StIdle: begin
                if (cnt_q < QFULL) state_d = StReq;
            end
            StReq: begin
                hold_d = req_addr;
                if (inst_mem_valid) begin
                    push  = 1'b1;
                    fpc_d = fpc_q + XLEN'(4);
                    // Keep requesting only while the post-push queue still has room.
                    if (cnt_after >= QFULL) state_d = StIdle;
                end
            end
            StDiscard: begin
                if (inst_mem_valid) state_d = StReq;
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            push  = 1'b0;
            fpc_d = {redirect_pc[XLEN-1:2], 2'b00};
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            unique case (state_q)
                StIdle:    state_d = StReq;
                StReq:     state_d = inst_mem_valid ? StReq : StDiscard;
                StDiscard: state_d = StDiscard;
                default:   state_d = StIdle;
            endcase
        end else begin
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        inst_addr_valid = (state_q != StIdle);
        // While discarding, the abandoned request address stays on the bus.
        inst_addr       = (state_q == StDiscard) ? hold_q : req_addr;
        inst_out        = inst_valid ? q_inst[rd_q] : NOP_INST;
        inst_pc         = inst_valid ? q_pc[rd_q] : '0;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            fpc_q   <= RESET_PC;
            hold_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            hold_q  <= hold_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue storage; contents are only meaningful below cnt_q, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_pc[wr_q]   <= fpc_q;
            q_inst[wr_q] <= sel_inst;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory model answers
// requests after a programmable delay; each task drives one scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] inst_addr;
    logic        inst_addr_valid;
    logic        inst_mem_valid;
    logic [63:0] inst_mem;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        inst_valid;

    logic        mem_v = 1'b0;
    logic [63:0] mem_data = '0;
    logic        force_v = 1'b0;
    logic [63:0] force_data = '0;
    logic        mem_en = 1'b0;
    int          mem_delay = 0;
    int          wcnt = 0;
    int          hs_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    assign inst_mem_valid = mem_v | force_v;
    assign inst_mem       = force_v ? force_data : mem_data;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_addr       (inst_addr),
        .inst_addr_valid (inst_addr_valid),
        .inst_mem_valid  (inst_mem_valid),
        .inst_mem        (inst_mem),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid)
    );

    always #5 clk = ~clk;

    // Memory model: low half = A000_0000 ^ addr, high half = B000_0000 ^ addr.
    always @(negedge clk) begin
        if (rst) begin
            mem_v = 1'b0;
            wcnt  = 0;
        end else begin
            if (mem_v) begin
                mem_v = 1'b0;
                wcnt  = 0;
            end
            if (mem_en && inst_addr_valid) begin
                if (wcnt >= mem_delay) begin
                    mem_v    = 1'b1;
                    mem_data = {32'hB000_0000 ^ inst_addr[31:0], 32'hA000_0000 ^ inst_addr[31:0]};
                end else begin
                    wcnt = wcnt + 1;
                end
            end
        end
    end

    // Count accepted handshakes.
    always @(posedge clk) begin
        if (!rst && inst_addr_valid && inst_mem_valid) hs_cnt = hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int delay);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        force_v        = 1'b0;
        mem_en         = 1'b1;
        mem_delay      = delay;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset_run();
        do_reset(0);
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || inst_out !== 32'h00000013 || inst_pc !== 64'h0)
            $display("FAIL reset_out got v=%b out=%h pc=%h want v=0 out=00000013 pc=0",
                     inst_valid, inst_out, inst_pc);
        else n_pass++;
        n_checks++;
        if (inst_addr_valid !== 1'b0 || inst_addr !== 64'h0)
            $display("FAIL reset_req got av=%b a=%h want av=0 a=0", inst_addr_valid, inst_addr);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_addr_valid !== 1'b1 || inst_addr !== 64'h0 || inst_valid !== 1'b0)
            $display("FAIL run_first_req got av=%b a=%h v=%b want av=1 a=0 v=0",
                     inst_addr_valid, inst_addr, inst_valid);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'hA000_0000 ||
            inst_addr !== 64'h0)
            $display("FAIL run_i0 got v=%b pc=%h out=%h a=%h want v=1 pc=0 out=a0000000 a=0",
                     inst_valid, inst_pc, inst_out, inst_addr);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h4 || inst_out !== 32'hB000_0000 ||
            inst_addr !== 64'h8)
            $display("FAIL run_i1 got v=%b pc=%h out=%h a=%h want v=1 pc=4 out=b0000000 a=8",
                     inst_valid, inst_pc, inst_out, inst_addr);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h8 || inst_out !== 32'hA000_0008 ||
            inst_addr !== 64'h8)
            $display("FAIL run_i2 got v=%b pc=%h out=%h a=%h want v=1 pc=8 out=a0000008 a=8",
                     inst_valid, inst_pc, inst_out, inst_addr);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'hC || inst_out !== 32'hB000_0008 ||
            inst_addr !== 64'h10)
            $display("FAIL run_i3 got v=%b pc=%h out=%h a=%h want v=1 pc=c out=b0000008 a=10",
                     inst_valid, inst_pc, inst_out, inst_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        int base;
        int waited;
        do_reset(0);
        stall = 1'b1;
        base  = hs_cnt;
        repeat (10) tick();
        #1;
        n_checks++;
        if (hs_cnt - base !== 2)
            $display("FAIL stall_pushes got %0d want 2", hs_cnt - base);
        else n_pass++;
        n_checks++;
        if (inst_addr_valid !== 1'b0 || inst_valid !== 1'b0 || inst_out !== 32'h00000013)
            $display("FAIL stall_idle got av=%b v=%b out=%h want av=0 v=0 out=00000013",
                     inst_addr_valid, inst_valid, inst_out);
        else n_pass++;
        stall = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'hA000_0000)
            $display("FAIL stall_rel0 got v=%b pc=%h out=%h want v=1 pc=0 out=a0000000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h4 || inst_out !== 32'hB000_0000)
            $display("FAIL stall_rel1 got v=%b pc=%h out=%h want v=1 pc=4 out=b0000000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
        waited = 0;
        do begin
            tick(); #1;
            waited++;
        end while (!inst_valid && waited < 20);
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h8 || inst_out !== 32'hA000_0008)
            $display("FAIL stall_rel2 got v=%b pc=%h out=%h want v=1 pc=8 out=a0000008",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
    endtask

    task automatic test_redirect_idle();
        do_reset(0);
        stall = 1'b1;
        repeat (10) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1006;
        stall          = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0)
            $display("FAIL rdi_suppress got v=%b want 0", inst_valid);
        else n_pass++;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (inst_addr_valid !== 1'b1 || inst_addr !== 64'h1000 || inst_valid !== 1'b0)
            $display("FAIL rdi_req got av=%b a=%h v=%b want av=1 a=1000 v=0",
                     inst_addr_valid, inst_addr, inst_valid);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h1004 || inst_out !== 32'hB000_1000)
            $display("FAIL rdi_first got v=%b pc=%h out=%h want v=1 pc=1004 out=b0001000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h1008 || inst_out !== 32'hA000_1008)
            $display("FAIL rdi_second got v=%b pc=%h out=%h want v=1 pc=1008 out=a0001008",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
    endtask

    task automatic test_redirect_inflight();
        int waited;
        bit leaked;
        do_reset(3);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (inst_addr_valid !== 1'b1 || inst_addr !== 64'h0)
            $display("FAIL rdf_hold1 got av=%b a=%h want av=1 a=0", inst_addr_valid, inst_addr);
        else n_pass++;
        tick(); tick(); #1;
        n_checks++;
        if (inst_addr_valid !== 1'b1 || inst_addr !== 64'h0)
            $display("FAIL rdf_hold3 got av=%b a=%h want av=1 a=0", inst_addr_valid, inst_addr);
        else n_pass++;
        waited = 0;
        leaked = 1'b0;
        do begin
            tick(); #1;
            waited++;
            if (inst_valid) leaked = 1'b1;
        end while (inst_addr === 64'h0 && waited < 10);
        n_checks++;
        if (inst_addr !== 64'h2000 || leaked)
            $display("FAIL rdf_target got a=%h leaked=%b want a=2000 leaked=0", inst_addr, leaked);
        else n_pass++;
        waited = 0;
        while (!inst_valid && waited < 20) begin
            tick(); #1;
            waited++;
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h2000 || inst_out !== 32'hA000_2000)
            $display("FAIL rdf_first got v=%b pc=%h out=%h want v=1 pc=2000 out=a0002000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
    endtask

    task automatic test_redirect_same_cycle();
        do_reset(0);
        tick(); tick(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0)
            $display("FAIL rds_suppress got v=%b want 0", inst_valid);
        else n_pass++;
        tick();
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || inst_addr_valid !== 1'b1 || inst_addr !== 64'h3000)
            $display("FAIL rds_flush got v=%b av=%b a=%h want v=0 av=1 a=3000",
                     inst_valid, inst_addr_valid, inst_addr);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h3000 || inst_out !== 32'hA000_3000)
            $display("FAIL rds_first got v=%b pc=%h out=%h want v=1 pc=3000 out=a0003000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
    endtask

    task automatic test_reset_midreq();
        do_reset(0);
        repeat (4) tick();
        mem_en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        force_v    = 1'b1;
        force_data = 64'hDEAD_BEEF_DEAD_BEEF;
        #1;
        n_checks++;
        if (inst_addr_valid !== 1'b0 || inst_addr !== 64'h0 || inst_valid !== 1'b0)
            $display("FAIL rmr_reset got av=%b a=%h v=%b want av=0 a=0 v=0",
                     inst_addr_valid, inst_addr, inst_valid);
        else n_pass++;
        tick();
        force_v = 1'b0;
        mem_en  = 1'b1;
        #1;
        n_checks++;
        if (inst_addr_valid !== 1'b1 || inst_addr !== 64'h0 || inst_valid !== 1'b0)
            $display("FAIL rmr_stray got av=%b a=%h v=%b want av=1 a=0 v=0",
                     inst_addr_valid, inst_addr, inst_valid);
        else n_pass++;
        tick(); #1;
        n_checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_out !== 32'hA000_0000)
            $display("FAIL rmr_restart got v=%b pc=%h out=%h want v=1 pc=0 out=a0000000",
                     inst_valid, inst_pc, inst_out);
        else n_pass++;
    endtask

    initial begin
        test_reset_run();
        test_stall();
        test_redirect_idle();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_reset_midreq();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
